ifu_fetch: RTL and testbench

- Instruction fetch unit: holds the PC, fetches one instruction at a time from instruction memory over a req/ack handshake, and presents it to decode through a valid/ready handshake.
- When decode accepts an instruction, it returns the s_npc select, the branch zero flag and the jr target. These are consumed in the same cycle to compute the next PC.
- Non-speculative: exactly one instruction is in flight, so no flush logic exists.

---
 rtl/ifu_fetch_pkg.sv | 29 ++
 rtl/ifu_fetch_npc_calc.sv | 54 +++++
 rtl/ifu_fetch.sv | 121 ++++++++++++
 tb/tb_ifu_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
//   Constants and types shared by the instruction fetch unit and its next-PC
//   calculator. The s_npc encodings must match the control decoder.
//   Contents:
//     S_NPC_*        next-PC select encodings
//     ifu_state_t    fetch FSM state codes
//     IFU_RESET_PC   default PC after reset
//     branch_offset  sign-extended, word-scaled beq displacement
package ifu_fetch_pkg;

    localparam logic [1:0] S_NPC_BEQ = 2'b00;
    localparam logic [1:0] S_NPC_JR  = 2'b01;
    localparam logic [1:0] S_NPC_J   = 2'b10;
    localparam logic [1:0] S_NPC_PC4 = 2'b11;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'b00,
        IFU_REQ  = 2'b01,
        IFU_HOLD = 2'b10
    } ifu_state_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

    // 16-bit immediate -> signed word displacement in bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// npc_calc
//   Purely combinational next-PC selection for the fetch unit.
//   Ports:
//     pc          PC of the instruction being retired
//     instr       the instruction word (immediate / jump target fields)
//     s_npc       next-PC select from the control decoder
//     zero        beq condition from the ALU
//     ra_data     jr target (rs value)
//     npc         selected next PC (all arithmetic modulo 2^32)
//     jr_misalign high when a jr target has nonzero low bits
module npc_calc
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  s_npc,
    input  logic        zero,
    input  logic [31:0] ra_data,
    output logic [31:0] npc,
    output logic        jr_misalign
);

    logic [31:0] pc_plus4;
    logic        unused_opcode;

    assign pc_plus4      = pc + 32'd4;
    // opcode field does not influence the target computation
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        npc         = pc_plus4;
        jr_misalign = 1'b0;
        case (s_npc)
            S_NPC_BEQ: begin
                if (zero) begin
                    npc = pc_plus4 + branch_offset(instr[15:0]);
                end
            end
            S_NPC_J: begin
                // region bits come from the sequential address, not pc itself
                npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            end
            S_NPC_JR: begin
                // low bits are forced to word alignment; the fault is only flagged
                npc         = {ra_data[31:2], 2'b00};
                jr_misalign = |ra_data[1:0];
            end
            default: begin
                npc = pc_plus4;
            end
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Non-speculative instruction fetch unit. Holds the PC, fetches one word at a
//   time over a req/ack handshake and presents it to decode via valid/ready.
//   The next PC is computed from decode's feedback on the accept edge.
//   Ports:
//     clk, rst                   clock, asynchronous active-low reset
//     imem_req/imem_addr         fetch request and address (= pc)
//     imem_ack/imem_rdata        memory response, data valid with ack
//     instr/instr_valid          held instruction to decode
//     instr_ready                decode accepts the held instruction
//     s_npc, zero, ra_data       next-PC controls, sampled on accept
//     pc_out, pc_plus4           PC of the held instruction and PC+4
//     instr_cnt                  accepted-instruction counter (wraps)
//     misalign                   sticky misaligned jr target flag
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic [1:0]       s_npc,
    input  logic             zero,
    input  logic [31:0]      ra_data,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             misalign
);

    ifu_state_t       state_reg, state_next;
    logic [31:0]      pc_reg;
    logic [31:0]      instr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             misalign_reg;

    logic             load_instr;
    logic             accept;
    logic [31:0]      npc;
    logic             jr_misalign;

    npc_calc u_npc_calc (
        .pc          (pc_reg),
        .instr       (instr_reg),
        .s_npc       (s_npc),
        .zero        (zero),
        .ra_data     (ra_data),
        .npc         (npc),
        .jr_misalign (jr_misalign)
    );

    // Handshake qualification lives here so stray ack/ready are ignored
    // outside the state that expects them.
    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_instr  = 1'b0;
        accept      = 1'b0;
        case (state_reg)
            IFU_IDLE: begin
                state_next = IFU_REQ;
            end
            IFU_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_next = IFU_HOLD;
                end
            end
            IFU_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    accept     = 1'b1;
                    state_next = IFU_REQ;
                end
            end
            default: begin
                state_next = IFU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IFU_IDLE;
            pc_reg       <= RESET_PC;
            instr_reg    <= 32'd0;
            cnt_reg      <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_instr) begin
                instr_reg <= imem_rdata;
            end
            if (accept) begin
                pc_reg  <= npc;
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (jr_misalign) begin
                    misalign_reg <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = pc_reg;
    assign instr     = instr_reg;
    assign pc_out    = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;
    assign instr_cnt = cnt_reg;
    assign misalign  = misalign_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch
//   Randomized and directed stimulus for ifu_fetch, checked every cycle against
//   a transaction-level model of the fetch unit kept in the bench. A second
//   instance (RESET_PC=FFFF_FFFC, 2-bit counter, zero-wait memory, ready tied
//   high) pins PC and counter wrap-around with literal expectations.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  s_npc;
    logic        zero;
    logic [31:0] ra_data;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] instr_cnt;
    logic        misalign;

    // wrap-check instance
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_instr_unused;
    logic        w_valid_unused;
    logic        w_ready;
    logic [1:0]  w_snpc;
    logic        w_zero;
    logic [31:0] w_ra;
    logic [31:0] w_pc_out_unused;
    logic [31:0] w_pc_plus4_unused;
    logic [1:0]  w_cnt;
    logic        w_mis_unused;

    assign w_ack = w_req;

    int vectors;
    int miscompares;

    // behavioural model state
    logic        m_idle;   // first edge after reset release still pending
    logic        m_have;   // an instruction is being held for decode
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;
    logic        m_mis;

    ifu_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .s_npc       (s_npc),
        .zero        (zero),
        .ra_data     (ra_data),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .instr_cnt   (instr_cnt),
        .misalign    (misalign)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .instr       (w_instr_unused),
        .instr_valid (w_valid_unused),
        .instr_ready (w_ready),
        .s_npc       (w_snpc),
        .zero        (w_zero),
        .ra_data     (w_ra),
        .pc_out      (w_pc_out_unused),
        .pc_plus4    (w_pc_plus4_unused),
        .instr_cnt   (w_cnt),
        .misalign    (w_mis_unused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Next PC straight from the ISA rules, using plain integer arithmetic.
    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] word,
                                              input logic [1:0] sel, input logic z,
                                              input logic [31:0] ra);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        case (sel)
            2'b00: begin
                off = int'($signed(word[15:0]));
                return z ? seq + 32'(off * 4) : seq;
            end
            2'b10:   return (seq & 32'hF000_0000) | (32'(word[25:0]) << 2);
            2'b01:   return ra & 32'hFFFF_FFFC;
            default: return seq;
        endcase
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_have  = 1'b0;
        m_pc    = 32'h0000_3000;
        m_instr = 32'd0;
        m_cnt   = 32'd0;
        m_mis   = 1'b0;
    endtask

    // Apply the effect of the upcoming rising edge given the current inputs.
    task automatic model_advance();
        if (rst) begin
            if (m_idle) begin
                m_idle = 1'b0;
            end else if (!m_have) begin
                if (imem_ack) begin
                    m_instr = imem_rdata;
                    m_have  = 1'b1;
                end
            end else if (instr_ready) begin
                if (s_npc == 2'b01 && ra_data[1:0] != 2'b00) m_mis = 1'b1;
                m_pc   = model_npc(m_pc, m_instr, s_npc, zero, ra_data);
                m_cnt  = m_cnt + 32'd1;
                m_have = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_req;
        exp_req = !m_idle && !m_have;
        chk("imem_req",    32'(imem_req),    32'(exp_req));
        chk("instr_valid", 32'(instr_valid), 32'(m_have));
        chk("imem_addr",   imem_addr,        m_pc);
        chk("pc_out",      pc_out,           m_pc);
        chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
        chk("instr",       instr,            m_instr);
        chk("instr_cnt",   instr_cnt,        m_cnt);
        chk("misalign",    32'(misalign),    32'(m_mis));
    endtask

    task automatic cycle();
        model_advance();
        @(negedge clk);
        check_outputs();
    endtask

    // One complete fetch/accept transaction, starting and ending in REQ.
    // Ignored inputs (ready in REQ, ack in HOLD, controls) are randomized.
    task automatic run_instr(input logic [31:0] word, input int wa, input logic [1:0] sel,
                             input logic z, input logic [31:0] ra, input int wr);
        logic [31:0] pc_acc;
        for (int i = 0; i < wa; i++) begin
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom);
            s_npc       = 2'($urandom);
            cycle();
        end
        imem_ack    = 1'b1;
        imem_rdata  = word;
        instr_ready = 1'($urandom);
        cycle();
        for (int i = 0; i < wr; i++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom);
            imem_rdata  = $urandom;
            cycle();
        end
        pc_acc      = m_pc;
        instr_ready = 1'b1;
        s_npc       = sel;
        zero        = z;
        ra_data     = ra;
        imem_ack    = 1'($urandom);
        cycle();
        $display("txn pc=%08h instr=%08h sel=%0d -> next pc=%08h cnt=%0d",
                 pc_acc, word, sel, pc_out, instr_cnt);
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        s_npc       = 2'($urandom);
        zero        = 1'($urandom);
        ra_data     = $urandom;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        imem_ack    = 1'b1;   // ack during reset must be ignored
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b0;
        s_npc       = 2'b11;
        zero        = 1'b0;
        ra_data     = 32'd0;
        w_rdata     = 32'd0;
        w_ready     = 1'b1;
        w_snpc      = 2'b11;
        w_zero      = 1'b0;
        w_ra        = 32'd0;
        model_reset();

        cycle();
        cycle();
        chk("reset_pc",  pc_out,          32'h0000_3000);
        chk("reset_req", 32'(imem_req),   32'd0);
        chk("reset_cnt", instr_cnt,       32'd0);

        // release: request must stay low for the first cycle
        rst = 1'b1;
        chk("req_low_after_release", 32'(imem_req), 32'd0);
        cycle();
        imem_ack = 1'b0;

        // sequential zero-wait fetches
        chk("seq_addr0", imem_addr, 32'h0000_3000);
        chk("w_addr0",   w_addr,    32'hFFFF_FFFC);
        run_instr(32'h0000_0020, 0, 2'b11, 1'b0, 32'd0, 0);
        chk("seq_addr1", imem_addr, 32'h0000_3004);
        chk("w_addr1",   w_addr,    32'h0000_0000);
        run_instr(32'h0000_0020, 0, 2'b11, 1'b0, 32'd0, 0);
        chk("seq_addr2", imem_addr, 32'h0000_3008);
        chk("w_addr2",   w_addr,    32'h0000_0004);
        run_instr(32'h0000_0020, 0, 2'b11, 1'b0, 32'd0, 0);
        chk("cnt_after_3", instr_cnt,   32'd3);
        chk("w_cnt3",      32'(w_cnt),  32'd3);
        run_instr(32'h0000_0020, 0, 2'b11, 1'b0, 32'd0, 0);
        chk("w_cnt_wrap",  32'(w_cnt),  32'd0);
        chk("w_addr4",     w_addr,      32'h0000_000C);
        chk("beq_pc",      imem_addr,   32'h0000_3010);

        // beq taken / not taken with offset -2 words
        run_instr(32'h1000_FFFE, 0, 2'b00, 1'b1, 32'd0, 0);
        chk("beq_taken", imem_addr, 32'h0000_300C);
        run_instr(32'h0000_0020, 0, 2'b11, 1'b0, 32'd0, 0);
        run_instr(32'h1000_FFFE, 0, 2'b00, 1'b0, 32'd0, 0);
        chk("beq_not_taken", imem_addr, 32'h0000_3014);

        // j from 0x3020
        for (int i = 0; i < 3; i++) run_instr(32'h0000_0020, 0, 2'b11, 1'b0, 32'd0, 0);
        chk("j_pc", imem_addr, 32'h0000_3020);
        run_instr(32'h0800_0C10, 0, 2'b10, 1'b0, 32'd0, 0);
        chk("j_target", imem_addr, 32'h0000_3040);

        // jr with misaligned target, flag must stick
        run_instr(32'h03E0_0008, 0, 2'b01, 1'b0, 32'h0000_3101, 0);
        chk("jr_target",   imem_addr,       32'h0000_3100);
        chk("jr_misalign", 32'(misalign),   32'd1);
        run_instr(32'h0000_0020, 0, 2'b11, 1'b0, 32'd0, 0);
        chk("misalign_sticky", 32'(misalign), 32'd1);

        // memory wait states then decode back-pressure
        run_instr(32'h1234_5678, 3, 2'b11, 1'b0, 32'd0, 4);
        chk("wait_next_addr", imem_addr, 32'h0000_3108);

        // wrap-around through the top of the address space
        run_instr(32'h03E0_0008, 0, 2'b01, 1'b0, 32'hFFFF_FFFC, 1);
        chk("jr_top", imem_addr, 32'hFFFF_FFFC);
        run_instr(32'h0000_0020, 1, 2'b11, 1'b0, 32'd0, 0);
        chk("seq_wrap", imem_addr, 32'h0000_0000);
        run_instr(32'h1000_FFFE, 0, 2'b00, 1'b1, 32'd0, 2);
        chk("beq_wrap", imem_addr, 32'hFFFF_FFFC);
        run_instr(32'h0800_0C00, 2, 2'b10, 1'b0, 32'd0, 0);
        chk("j_from_top", imem_addr, 32'h0000_3000);

        // reset while a request is outstanding
        imem_ack = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        model_reset();
        chk("req_drop_async", 32'(imem_req), 32'd0);
        check_outputs();
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        cycle();
        cycle();
        rst = 1'b1;
        chk("req_low_after_rerelease", 32'(imem_req), 32'd0);
        cycle();
        imem_ack = 1'b0;
        chk("restart_addr", imem_addr,      32'h0000_3000);
        chk("restart_cnt",  instr_cnt,      32'd0);
        chk("restart_mis",  32'(misalign),  32'd0);

        // randomized traffic; jr targets mostly aligned
        for (int n = 0; n < 150; n++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 15) != 0) ra = ra & 32'hFFFF_FFFC;
            run_instr($urandom, int'($urandom_range(0, 3)), 2'($urandom), 1'($urandom),
                      ra, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
